// File: rtl/uart_tx_arbiter_if.sv
// Purpose: bundles requester, arbiter-status and UART TX signals of uart_tx_arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req/pkt/size until grant; UART completion via tx_done level.
// Ports: req/pkt0..2/size0..2 (requesters in), grant/done/err/busy (status out),
//        tx_bytevect/tx_size/tx_reset (to UART), tx_done (from UART).
interface uart_tx_arbiter_if #(
  parameter int PACKET_SIZE = 64
);
  logic [2:0]               req;
  logic [8*PACKET_SIZE-1:0] pkt0;
  logic [8*PACKET_SIZE-1:0] pkt1;
  logic [8*PACKET_SIZE-1:0] pkt2;
  logic [15:0]              size0;
  logic [15:0]              size1;
  logic [15:0]              size2;
  logic [2:0]               grant;
  logic [2:0]               done;
  logic                     err;
  logic                     busy;
  logic [8*PACKET_SIZE-1:0] tx_bytevect;
  logic [15:0]              tx_size;
  logic                     tx_reset;
  logic                     tx_done;

  // Requester + UART side.
  modport master (
    output req, pkt0, pkt1, pkt2, size0, size1, size2, tx_done,
    input  grant, done, err, busy, tx_bytevect, tx_size, tx_reset
  );

  // Arbiter side.
  modport slave (
    input  req, pkt0, pkt1, pkt2, size0, size1, size2, tx_done,
    output grant, done, err, busy, tx_bytevect, tx_size, tx_reset
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter sharing one UART transmitter among three packet requesters.
// Latency: request-to-grant 1 cycle; back-to-back transfers separated by GAP+IDLE (2 cycles).
// Backpressure: requesters hold req until grant; UART paced by tx_done, with a WAIT timeout.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries all requester/UART signals.
module uart_tx_arbiter #(
  parameter int PACKET_SIZE    = 64,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);

  localparam logic [15:0] PKT_SZ16  = 16'(PACKET_SIZE);
  localparam logic [31:0] TIMER_MAX = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_WAIT, S_GAP} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               grant_q, grant_d;
  logic [2:0]               done_q, done_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;
  logic [8*PACKET_SIZE-1:0] tx_bytevect_q, tx_bytevect_d;
  logic [15:0]              tx_size_q, tx_size_d;
  logic                     tx_reset_q, tx_reset_d;
  logic [31:0]              timer_q, timer_d;
  logic [1:0]               last_q, last_d;
  logic [1:0]               cur_q, cur_d;
  logic                     arm_cnt_q, arm_cnt_d;

  logic [1:0]               win;
  logic [8*PACKET_SIZE-1:0] pkt_sel;
  logic [15:0]              size_sel;

  // Search starts one past the last granted requester; lower search offset wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] pick;
    int         idx;
    pick = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      idx = (int'(last) + 1 + k) % 3;
      if (r[idx]) pick = 2'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    win      = rr_pick(bus.req, last_q);
    pkt_sel  = bus.pkt0;
    size_sel = bus.size0;
    case (win)
      2'd1: begin pkt_sel = bus.pkt1; size_sel = bus.size1; end
      2'd2: begin pkt_sel = bus.pkt2; size_sel = bus.size2; end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = 3'b000;
    done_d        = 3'b000;
    err_d         = 1'b0;
    tx_bytevect_d = tx_bytevect_q;
    tx_size_d     = tx_size_q;
    tx_reset_d    = tx_reset_q;
    timer_d       = timer_q;
    last_d        = last_q;
    cur_d         = cur_q;
    arm_cnt_d     = arm_cnt_q;

    case (state_q)
      S_IDLE: begin
        tx_reset_d = 1'b1;
        if (|bus.req) begin
          cur_d         = win;
          grant_d       = 3'b001 << win;
          tx_bytevect_d = pkt_sel;
          tx_size_d     = (size_sel > PKT_SZ16) ? PKT_SZ16 : size_sel;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        if (tx_size_q == 16'd0) begin
          // Nothing to send: skip the UART entirely and report completion.
          done_d     = 3'b001 << cur_q;
          tx_reset_d = 1'b1;
          state_d    = S_GAP;
        end else begin
          tx_reset_d = 1'b0;
          arm_cnt_d  = 1'b0;
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        // tx_done is ignored here: it may still be high from the previous transfer.
        if (arm_cnt_q) begin
          timer_d = 32'd0;
          state_d = S_WAIT;
        end else begin
          arm_cnt_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.tx_done) begin
          done_d     = 3'b001 << cur_q;
          tx_reset_d = 1'b1;
          state_d    = S_GAP;
        end else if (timer_q == TIMER_MAX) begin
          done_d     = 3'b001 << cur_q;
          err_d      = 1'b1;
          tx_reset_d = 1'b1;
          state_d    = S_GAP;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_GAP: begin
        tx_reset_d = 1'b1;
        timer_d    = 32'd0;
        last_d     = cur_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      grant_q       <= 3'b000;
      done_q        <= 3'b000;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      tx_bytevect_q <= '0;
      tx_size_q     <= 16'd0;
      tx_reset_q    <= 1'b1;
      timer_q       <= 32'd0;
      last_q        <= 2'd2;
      cur_q         <= 2'd0;
      arm_cnt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      tx_bytevect_q <= tx_bytevect_d;
      tx_size_q     <= tx_size_d;
      tx_reset_q    <= tx_reset_d;
      timer_q       <= timer_d;
      last_q        <= last_d;
      cur_q         <= cur_d;
      arm_cnt_q     <= arm_cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.busy        = busy_q;
  assign bus.tx_bytevect = tx_bytevect_q;
  assign bus.tx_size     = tx_size_q;
  assign bus.tx_reset    = tx_reset_q;

endmodule
